// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue
//   Command/response queue in front of an I2C master core. Commands pushed
//   into a command FIFO are issued to the core one at a time through the
//   cmd/stb handshake; each WRITE/READ result is captured in a response FIFO.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cq_wdata, cq_we      command entry {cmd[1:0], ack, data[7:0]} and push
//   cq_full              command FIFO full
//   rsp_rdata, rsp_re    response head {ack, data[7:0]} (0 when empty), pop
//   rsp_empty            response FIFO empty
//   flush                clear both FIFOs, drop any in-flight response
//   busy                 commands pending or a command in flight
//   overflow             sticky: push attempted on a full command FIFO
//   cmd, data_in, ack_in command fields held towards the core
//   stb                  one-cycle command strobe to the core
//   data_out, ack_out    result from the core
//   ready                core idle and able to accept stb
module i2c_cmd_queue #(
  parameter int CQ_LOG2 = 4,
  parameter int RQ_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] cq_wdata,
  input  logic        cq_we,
  output logic        cq_full,
  output logic [8:0]  rsp_rdata,
  input  logic        rsp_re,
  output logic        rsp_empty,
  input  logic        flush,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  cmd,
  output logic [7:0]  data_in,
  output logic        ack_in,
  output logic        stb,
  input  logic [7:0]  data_out,
  input  logic        ack_out,
  input  logic        ready
);

  localparam int CQ_N = 1 << CQ_LOG2;
  localparam int RQ_N = 1 << RQ_LOG2;
  localparam logic [CQ_LOG2:0] CQ_DEPTH = (CQ_LOG2+1)'(CQ_N);
  localparam logic [RQ_LOG2:0] RQ_DEPTH = (RQ_LOG2+1)'(RQ_N);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [10:0]        cq_mem [CQ_N];
  logic [CQ_LOG2-1:0] cq_wptr, cq_rptr;
  logic [CQ_LOG2:0]   cq_count;
  logic               cq_empty, cq_push, cq_pop;
  logic [10:0]        cq_head;

  logic [8:0]         rq_mem [RQ_N];
  logic [RQ_LOG2-1:0] rq_wptr, rq_rptr;
  logic [RQ_LOG2:0]   rq_count;
  logic               rq_full, rq_push, rq_pop;

  logic               issue;
  logic               discard;

  assign cq_empty  = (cq_count == '0);
  assign cq_full   = (cq_count == CQ_DEPTH);
  assign cq_head   = cq_mem[cq_rptr];
  assign rsp_empty = (rq_count == '0);
  assign rq_full   = (rq_count == RQ_DEPTH);
  assign rsp_rdata = rsp_empty ? 9'd0 : rq_mem[rq_rptr];
  assign busy      = !cq_empty || (state_q != S_IDLE);

  // START/STOP (cmd[1]==0) produce no response, so only WRITE/READ need space.
  assign issue   = (state_q == S_IDLE) && !cq_empty && ready && !flush &&
                   (!cq_head[10] || !rq_full);
  assign cq_pop  = issue;
  // On a full FIFO a coincident pop frees the slot the push lands in.
  assign cq_push = cq_we && !flush && (!cq_full || cq_pop);

  assign rq_pop  = rsp_re && !rsp_empty && !flush;
  assign rq_push = (state_q == S_WAIT) && ready && cmd[1] && !discard && !flush &&
                   (!rq_full || rq_pop);

  // Command FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_wptr  <= '0;
      cq_rptr  <= '0;
      cq_count <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      cq_wptr  <= '0;
      cq_rptr  <= '0;
      cq_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (cq_push) cq_wptr <= cq_wptr + 1'b1;
      if (cq_pop)  cq_rptr <= cq_rptr + 1'b1;
      cq_count <= cq_count + {{CQ_LOG2{1'b0}}, cq_push} - {{CQ_LOG2{1'b0}}, cq_pop};
      if (cq_we && !cq_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wptr] <= cq_wdata;
  end

  // Response FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_wptr  <= '0;
      rq_rptr  <= '0;
      rq_count <= '0;
    end else if (flush) begin
      rq_wptr  <= '0;
      rq_rptr  <= '0;
      rq_count <= '0;
    end else begin
      if (rq_push) rq_wptr <= rq_wptr + 1'b1;
      if (rq_pop)  rq_rptr <= rq_rptr + 1'b1;
      rq_count <= rq_count + {{RQ_LOG2{1'b0}}, rq_push} - {{RQ_LOG2{1'b0}}, rq_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rq_push) rq_mem[rq_wptr] <= {ack_out, data_out};
  end

  // Sequencer state and latched command fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd     <= 2'b00;
      data_in <= 8'd0;
      ack_in  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        cmd     <= cq_head[10:9];
        ack_in  <= cq_head[8];
        data_in <= cq_head[7:0];
      end
    end
  end

  // A flush while a command is on the core lets it finish but drops its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= 1'b0;
    end else if (state_q == S_WAIT && ready) begin
      discard <= 1'b0;
    end else if (flush && state_q != S_IDLE) begin
      discard <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    stb     = 1'b0;
    unique case (state_q)
      S_IDLE:   if (issue) state_d = S_ISSUE;
      S_ISSUE: begin
        stb     = 1'b1;
        state_d = S_SETTLE;
      end
      // The core drops ready only in the cycle after stb, so skip one cycle.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT:   if (ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
module tb_i2c_cmd_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cq_wdata;
  logic        cq_we;
  logic        cq_full;
  logic [8:0]  rsp_rdata;
  logic        rsp_re;
  logic        rsp_empty;
  logic        flush;
  logic        busy;
  logic        overflow;
  logic [1:0]  cmd;
  logic [7:0]  data_in;
  logic        ack_in;
  logic        stb;
  logic [7:0]  data_out;
  logic        ack_out;
  logic        ready;

  logic        core_rdy;
  logic        hold;
  logic        fixed_mode;

  assign ready = core_rdy & ~hold;

  always #5 clk = ~clk;

  i2c_cmd_queue #(.CQ_LOG2(4), .RQ_LOG2(4)) dut (
    .clk(clk), .rst_n(rst_n), .cq_wdata(cq_wdata), .cq_we(cq_we),
    .cq_full(cq_full), .rsp_rdata(rsp_rdata), .rsp_re(rsp_re),
    .rsp_empty(rsp_empty), .flush(flush), .busy(busy), .overflow(overflow),
    .cmd(cmd), .data_in(data_in), .ack_in(ack_in), .stb(stb),
    .data_out(data_out), .ack_out(ack_out), .ready(ready)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain queues for both FIFOs plus the core's view of
  // the command in flight.
  logic [10:0] cq_m[$];
  logic [8:0]  rq_m[$];
  logic        m_ovf = 1'b0;
  logic        att_push = 1'b0, att_flush = 1'b0;
  logic [10:0] att_data = '0;
  int          rq_pre = 0;
  logic        core_pending = 1'b0, core_rw = 1'b0, core_discard = 1'b0;
  int          core_cnt = 0;
  int          stb_count = 0;
  logic        prev_stb = 1'b0;
  logic [10:0] e;

  // Core model and response-side model, advanced on the active edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      rq_m.delete();
      core_rdy     <= 1'b1;
      data_out     <= 8'd0;
      ack_out      <= 1'b0;
      core_pending = 1'b0;
      core_rw      = 1'b0;
      core_discard = 1'b0;
      core_cnt     = 0;
      att_push     = 1'b0;
      att_flush    = 1'b0;
      att_data     = '0;
      rq_pre       = 0;
    end else begin
      att_push  = cq_we;
      att_flush = flush;
      att_data  = cq_wdata;
      rq_pre    = rq_m.size();
      if (flush) rq_m.delete();
      else begin
        if (rsp_re && rq_m.size() != 0) void'(rq_m.pop_front());
        if (core_pending && ready && core_rw && !core_discard)
          rq_m.push_back({ack_out, data_out});
      end
      if (stb) begin
        core_pending = 1'b1;
        core_rw      = cmd[1];
        core_discard = flush;
        core_cnt     = fixed_mode ? 8 : $urandom_range(1, 6);
        core_rdy     <= 1'b0;
      end else if (core_pending) begin
        if (ready) begin
          core_pending = 1'b0;
          core_discard = 1'b0;
        end else begin
          if (flush) core_discard = 1'b1;
          if (core_cnt <= 1) begin
            core_rdy <= 1'b1;
            data_out <= fixed_mode ? 8'h5C : 8'($urandom);
            ack_out  <= fixed_mode ? 1'b0 : 1'($urandom);
          end else begin
            core_cnt = core_cnt - 1;
          end
        end
      end
    end
  end

  // Command-side model and per-cycle output checks, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cq_m.delete();
      m_ovf    = 1'b0;
      prev_stb = 1'b0;
    end else begin
      if (stb) begin
        stb_count++;
        check_eq("stb_width", prev_stb, 1'b0);
        if (cq_m.size() == 0) check_eq("stb_without_cmd", 1'b1, 1'b0);
        else begin
          e = cq_m.pop_front();
          check_eq("issue_cmd", cmd, e[10:9]);
          check_eq("issue_data", data_in, e[7:0]);
          check_eq("issue_ack", ack_in, e[8]);
          if (e[10]) check_eq("rsp_space_gate", rq_pre < 16, 1'b1);
        end
      end
      if (att_flush) begin
        cq_m.delete();
        m_ovf = 1'b0;
      end else if (att_push) begin
        if (cq_m.size() < 16) cq_m.push_back(att_data);
        else m_ovf = 1'b1;
      end
      check_eq("cq_full", cq_full, cq_m.size() == 16);
      check_eq("overflow", overflow, m_ovf);
      check_eq("busy", busy, (cq_m.size() != 0) || stb || core_pending);
      check_eq("rsp_empty", rsp_empty, rq_m.size() == 0);
      check_eq("rsp_rdata", rsp_rdata, (rq_m.size() != 0) ? rq_m[0] : 9'd0);
      prev_stb = stb;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) break;
      tick();
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic drain(input string tag);
    rsp_re = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (rsp_empty) break;
      tick();
    end
    rsp_re = 1'b0;
    check_eq(tag, rsp_empty, 1'b1);
  endtask

  int base;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    cq_we = 0; cq_wdata = '0; rsp_re = 0; flush = 0; hold = 0; fixed_mode = 1;
    tick(); tick();
    check_eq("rst_stb", stb, 1'b0);
    check_eq("rst_cmd", cmd, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rsp_empty", rsp_empty, 1'b1);
    check_eq("rst_rsp_rdata", rsp_rdata, 9'd0);
    check_eq("rst_cq_full", cq_full, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic burst: START, WRITE 0xA4, READ with NAK, STOP.
    base = stb_count;
    cq_we = 1; cq_wdata = {2'b00, 1'b0, 8'h00};
    tick();
    cq_we = 0;
    check_eq("lat_busy_c1", busy, 1'b1);
    check_eq("lat_stb_c1", stb, 1'b0);
    tick();
    check_eq("lat_stb_c2", stb, 1'b1);
    cq_we = 1; cq_wdata = {2'b10, 1'b0, 8'hA4}; tick();
    cq_wdata = {2'b11, 1'b1, 8'h00}; tick();
    cq_wdata = {2'b01, 1'b0, 8'h00}; tick();
    cq_we = 0;
    wait_idle("burst_idle", 400);
    check_eq("burst_stb_count", stb_count - base, 4);
    check_eq("burst_rsp0", rsp_rdata, 9'h05C);
    rsp_re = 1; tick();
    check_eq("burst_rsp1", rsp_rdata, 9'h05C);
    tick(); rsp_re = 0;
    check_eq("burst_rsp_drained", rsp_empty, 1'b1);

    // Command FIFO overflow with the core held busy.
    hold = 1; tick();
    for (int i = 0; i < 17; i++) begin
      cq_we = 1; cq_wdata = 11'($urandom);
      tick();
      if (i == 15) begin
        check_eq("full_after_16", cq_full, 1'b1);
        check_eq("no_ovf_at_16", overflow, 1'b0);
      end
    end
    cq_we = 0;
    check_eq("ovf_after_17", overflow, 1'b1);
    flush = 1; tick(); flush = 0;
    check_eq("flush_cq_full", cq_full, 1'b0);
    check_eq("flush_overflow", overflow, 1'b0);
    check_eq("flush_busy", busy, 1'b0);
    hold = 0; tick();

    // Response FIFO full blocks further READs until a pop.
    fixed_mode = 0;
    for (int i = 0; i < 16; i++) begin
      cq_we = 1; cq_wdata = {2'b11, 1'($urandom), 8'h00};
      tick();
    end
    cq_we = 0;
    wait_idle("rq_fill_idle", 600);
    check_eq("rq_fill_nonempty", rsp_empty, 1'b0);
    cq_we = 1; cq_wdata = {2'b11, 1'b0, 8'h00}; tick(); cq_we = 0;
    base = stb_count;
    repeat (20) tick();
    check_eq("rq_full_no_stb", stb_count - base, 0);
    check_eq("rq_full_busy", busy, 1'b1);
    rsp_re = 1; tick(); rsp_re = 0;
    for (int i = 0; i < 2; i++) begin
      if (stb_count != base) break;
      tick();
    end
    check_eq("rq_pop_then_stb", stb_count - base, 1);
    wait_idle("rq_17_idle", 100);
    drain("rq_drain");

    // Flush while waiting on a READ.
    fixed_mode = 1;
    cq_we = 1; cq_wdata = {2'b11, 1'b0, 8'h00}; tick(); cq_we = 0;
    tick();
    check_eq("flushwait_stb", stb, 1'b1);
    tick(); tick(); tick();
    flush = 1; tick(); flush = 0;
    wait_idle("flushwait_idle", 100);
    tick(); tick();
    check_eq("flushwait_rsp_empty", rsp_empty, 1'b1);

    // Asynchronous reset in SETTLE with a command still queued.
    cq_we = 1; cq_wdata = {2'b10, 1'b1, 8'hA5}; tick();
    cq_wdata = {2'b01, 1'b0, 8'h00}; tick(); cq_we = 0;
    check_eq("rst_mid_stb_seen", stb, 1'b1);
    tick();
    rst_n = 0; #1;
    check_eq("arst_stb", stb, 1'b0);
    check_eq("arst_cmd", cmd, 2'b00);
    check_eq("arst_data_in", data_in, 8'h00);
    check_eq("arst_ack_in", ack_in, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_cq_full", cq_full, 1'b0);
    check_eq("arst_rsp_empty", rsp_empty, 1'b1);
    check_eq("arst_rsp_rdata", rsp_rdata, 9'd0);
    check_eq("arst_overflow", overflow, 1'b0);
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_rsp_empty", rsp_empty, 1'b1);

    // Randomized traffic: pushes at full with issue, pops at empty with push.
    fixed_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      cq_we    = ($urandom % 10) < 7;
      cq_wdata = 11'($urandom);
      rsp_re   = ($urandom % 10) < 3;
      flush    = ($urandom % 100) == 0;
      tick();
    end
    cq_we = 0; rsp_re = 0; flush = 0;
    wait_idle("rand_idle", 2000);
    drain("rand_drain");
    check_eq("rand_model_cq_empty", cq_m.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
